// File: rtl/arm_pkg.sv
// arm_pkg: definitions shared by the ARM pipeline front end.
//   fetch_state_t    - fetch state machine states (BOOT, RUN, HALT)
//   NOP_WORD         - flushed IF/ID instruction value, also the out-of-range imem word
//   WORD_BYTES       - PC increment per sequential fetch
//   DEFAULT_RESET_PC - PC loaded on reset unless the instance overrides it
//   word_align()     - clears the byte-offset bits of an address
package arm_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: 65-bit IF/ID pipeline register (pc, instr, valid).
//   clk, rst_n          - clock, asynchronous active-low reset (clears to zero)
//   hold                - keep the current contents
//   flush               - clear the contents; takes priority over hold
//   d_pc/d_instr/d_valid - next contents
//   q_pc/q_instr/q_valid - registered contents
module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic        d_valid,
    output logic [31:0] q_pc,
    output logic [31:0] q_instr,
    output logic        q_valid
);

    logic [64:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (flush) begin
            data <= '0;
        end else if (!hold) begin
            data <= {d_valid, d_instr, d_pc};
        end
    end

    assign q_valid = data[64];
    assign q_instr = data[63:32];
    assign q_pc    = data[31:0];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with integrated IF/ID register.
//   clk, rst_n    - clock, asynchronous active-low reset
//   freeze        - hazard stall: holds PC and IF/ID
//   branch_taken  - redirect from EXE; overrides freeze and leaves HALT
//   branch_addr   - redirect byte address (low two bits ignored)
//   imem_addr     - current PC to instruction memory
//   imem_instr    - combinational instruction word for imem_addr
//   if_id_pc      - registered PC+4 of the fetched instruction
//   if_id_instr   - registered instruction word
//   if_id_valid   - registered, 1 for a real fetched instruction
//   halted        - 1 while fetch is stopped at end of program
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx, pc_inc;
    logic         ifid_hold, ifid_flush;

    assign pc_inc    = pc + WORD_BYTES;
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        unique case (state)
            BOOT: begin
                state_nx = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_nx      = word_align(branch_addr);
                    ifid_flush = 1'b1;
                end else if (freeze) begin
                    ifid_hold = 1'b1;
                end else if (HALT_ON_ZERO && imem_instr == NOP_WORD) begin
                    state_nx   = HALT;
                    ifid_flush = 1'b1;
                end else begin
                    pc_nx     = pc_inc;
                    ifid_hold = 1'b0;
                end
            end
            HALT: begin
                // IF/ID was cleared on entry; keep forcing it clear so a
                // stale freeze cannot matter here.
                ifid_flush = 1'b1;
                if (branch_taken) begin
                    pc_nx    = word_align(branch_addr);
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (ifid_hold),
        .flush   (ifid_flush),
        .d_pc    (pc_inc),
        .d_instr (imem_instr),
        .d_valid (1'b1),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr),
        .q_valid (if_id_valid)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the ARM pipeline with an integrated IF/ID pipeline register. It holds the program counter (PC) and drives the word address into the combinational instruction memory. It captures the returned instruction word together with PC+4 for the decode stage. It also applies hazard freezes and branch redirects from downstream stages, and stops fetching when the end of the program is reached.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; word-aligned.
- `HALT_ON_ZERO`, default 1: when 1, a fetched word of 32'h0000_0000 (instruction memory out-of-range value) stops fetch.

Ports:
- `clk`  in  1  Pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `freeze`  in  1  Hazard stall from the hazard unit. Holds the PC and IF/ID contents.
- `branch_taken`  in  1  Redirect from the EXE stage.
- `branch_addr`  in  32  Byte address of the branch target.
- `imem_addr`  out  32  Byte address to instruction memory. Equals the current PC (combinational from the PC register).
- `imem_instr`  in  32  Instruction word returned combinationally for `imem_addr`.
- `if_id_pc`  out  32  Registered PC+4 of the fetched instruction.
- `if_id_instr`  out  32  Registered instruction word.
- `if_id_valid`  out  1  Registered; 1 when `if_id_instr` is a real fetched instruction.
- `halted`  out  1  1 while the state machine is in HALT.

## Operation
- State machine states:
  - BOOT: the first cycle after reset release.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- BOOT → RUN unconditionally on the first clock edge after reset release. No capture occurs in BOOT: the PC holds and `if_id_valid` stays 0.
- RUN, per-edge priority, highest first:
  - `branch_taken`:
    - PC <= {branch_addr[31:2], 2'b00}.
    - IF/ID flushed: instr 0, pc 0, valid 0.
    - `freeze` is ignored in this cycle.
  - `freeze`: PC and all IF/ID fields hold their values.
  - Zero-word halt: applies when `HALT_ON_ZERO` = 1 and `imem_instr` = 0.
    - Go to HALT.
    - PC holds.
    - IF/ID flushed.
  - Otherwise (normal fetch):
    - PC <= PC + 4.
    - if_id_pc <= PC + 4.
    - if_id_instr <= imem_instr.
    - if_id_valid <= 1.
- HALT:
  - PC holds and IF/ID remains flushed. `freeze` has no effect.
  - `branch_taken` loads the PC from `branch_addr` and returns to RUN. This is needed because an older in-flight branch can redirect past the end-of-program word.
- Arithmetic:
  - PC+4 is a 32-bit unsigned add.
  - 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
  - `branch_addr[1:0]` is always discarded.
- An ARM self-branch (e.g. 32'hEAFF_FFFF) does not halt. It simply loops through redirects.

## Timing
- Reset (asserted asynchronously, immediately):
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `if_id_pc` = 0, `if_id_instr` = 0, `if_id_valid` = 0.
  - `halted` = 0; state = BOOT.
- Reset asserted mid-operation discards the state and all IF/ID contents in the same instant; no partial update.
- Fetch latency:
  - The instruction at address A appears on the IF/ID outputs one edge after the PC equals A in RUN with no freeze.
  - Throughput is one instruction per cycle.
- Branch penalty: the edge that samples `branch_taken` flushes IF/ID. The target instruction appears on IF/ID at the following edge, giving exactly one bubble from this stage.
- `freeze` held for N cycles extends the IF/ID hold by exactly N cycles. No instruction is lost or duplicated.
- `halted` is registered and rises on the same edge that enters HALT.

## Structure
- Shared package `arm_pkg`:
  - `fetch_state_t` enum (BOOT, RUN, HALT).
  - `NOP_WORD` = 32'h0, `WORD_BYTES` = 4.
  - The default `RESET_PC` constant.
- One sub-module, `if_id_reg`: a 65-bit register with `hold` and `flush` inputs and asynchronous active-low reset. `flush` has priority over `hold`.
- The PC register, next-PC mux and state machine live in `fetch_stage` itself.

## Test plan
- Reset, then release; imem returns 32'hE3A0_0014 at address 0:
  - BOOT cycle: `if_id_valid` = 0.
  - Next edge: if_id_pc = 4, if_id_instr = 32'hE3A0_0014, valid = 1, imem_addr = 4.
- Run 5 cycles, then `freeze` for 3 cycles: imem_addr and all IF/ID outputs are constant for exactly 3 edges, then resume with the next sequential word.
- `branch_taken` = 1 with `branch_addr` = 32'h0000_0053 while `freeze` = 1:
  - Next edge: imem_addr = 32'h50 and valid = 0.
  - The edge after that: if_id_pc = 32'h54.
- `HALT_ON_ZERO` = 1, imem returns 0 at 32'hBC:
  - Next edge: halted = 1, valid = 0, imem_addr stays 32'hBC for 10+ cycles.
  - Then a `branch_taken` to 32'h0 resumes fetch from address 0 with halted = 0.
- With the PC forced to 32'hFFFF_FFFC via branch, a normal fetch gives if_id_pc = 0 and imem_addr = 0.
- Assert `rst_n` low mid-branch (with `branch_taken` = 1): imem_addr = `RESET_PC` and valid = 0 immediately, with no clock edge required.
